// File: rtl/uart_tx_fifo_if.sv
// Host write port and UART-core launch port of the transmit FIFO.
// The master modport is the driving side (host plus core status), slave is the FIFO.
interface uart_tx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              flush;
    logic              ovf_clr;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        tx_data;
    logic              start_tx;
    logic              tx_done;
    logic              busy;

    modport master (
        output wr_en, wr_data, flush, ovf_clr, tx_done,
        input  full, empty, count, overflow, tx_data, start_tx, busy
    );

    modport slave (
        input  wr_en, wr_data, flush, ovf_clr, tx_done,
        output full, empty, count, overflow, tx_data, start_tx, busy
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO plus frame launcher feeding the UART core one byte at a time.
// tx_data is held between pops because the core samples it throughout the frame.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    uart_tx_fifo_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        SENDING = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W + 1){1'b0}};

    logic [7:0]        mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_s;
    logic [ADDR_W-1:0] rd_ptr_r, rd_ptr_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic              full_r, empty_r;
    logic              overflow_r, overflow_s;
    logic              wr_acc_s, wr_drop_s, pop_s;
    state_t            state_r, state_s;
    logic [7:0]        tx_data_r, tx_data_s;
    logic              start_tx_r, start_tx_s;
    logic              busy_r, busy_s;

    // A dropped write is judged on the registered full flag; a same-cycle pop cannot rescue it.
    always_comb begin
        wr_acc_s  = bus.wr_en & ~full_r & ~bus.flush;
        wr_drop_s = bus.wr_en & full_r;
    end

    // FIFO pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        if (bus.flush) begin
            wr_ptr_s = {ADDR_W{1'b0}};
            rd_ptr_s = {ADDR_W{1'b0}};
            count_s  = ZERO_C;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_s = wr_ptr_r + ADDR_W'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + ADDR_W'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({wr_acc_s, pop_s})
                2'b10:   count_s = count_r + (ADDR_W + 1)'(1);
                2'b01:   count_s = count_r - (ADDR_W + 1)'(1);
                default: count_s = count_r;
            endcase
        end
        if (wr_drop_s) begin
            overflow_s = 1'b1;
        end else if (bus.ovf_clr) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
    end

    // Launcher next-state and registered-output next values.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        tx_data_s  = tx_data_r;
        start_tx_s = start_tx_r;
        busy_s     = busy_r;
        case (state_r)
            IDLE: begin
                if (~empty_r & bus.tx_done) begin
                    pop_s      = 1'b1;
                    tx_data_s  = mem_r[rd_ptr_r];
                    start_tx_s = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = LAUNCH;
                end else begin
                    start_tx_s = 1'b0;
                    busy_s     = 1'b0;
                end
            end
            LAUNCH: begin
                if (~bus.tx_done) begin
                    start_tx_s = 1'b0;
                    state_s    = SENDING;
                end else begin
                    start_tx_s = 1'b1;
                end
            end
            SENDING: begin
                if (bus.tx_done) begin
                    busy_s  = 1'b0;
                    state_s = IDLE;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                start_tx_s = 1'b0;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
        endcase
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // FIFO state and flags; flags are derived from the next count so they stay registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= {ADDR_W{1'b0}};
            rd_ptr_r   <= {ADDR_W{1'b0}};
            count_r    <= ZERO_C;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            full_r     <= (count_s == DEPTH_C);
            empty_r    <= (count_s == ZERO_C);
            overflow_r <= overflow_s;
        end
    end

    // Launcher state and its registered outputs to the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            tx_data_r  <= 8'h00;
            start_tx_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_data_r  <= tx_data_s;
            start_tx_r <= start_tx_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.full     = full_r;
    assign bus.empty    = empty_r;
    assign bus.count    = count_r;
    assign bus.overflow = overflow_r;
    assign bus.tx_data  = tx_data_r;
    assign bus.start_tx = start_tx_r;
    assign bus.busy     = busy_r;

endmodule
